// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: funct3 codes, FSM states,
// and the store byte-enable / lane-replication helpers.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    // size is funct3[1:0]: 00 byte, 01 half, 10 word; 11 enables no lanes
    function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] off);
        case (size)
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            2'b10:   return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] wdata);
        case (size)
            2'b00:   return {4{wdata[7:0]}};
            2'b01:   return {2{wdata[15:0]}};
            default: return wdata;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_resp_if.sv
// Load/store request channel and read-data response channel between the MEM
// stage (master) and the data-memory responder (slave).
interface data_mem_resp_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;

    modport master (
        output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dmem_bram.sv
// Single-port synchronous RAM with per-byte write enables; one-cycle read latency.
// No reset: contents and read register power up undefined.
module dmem_bram #(
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic [3:0]            we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata
);
    logic [31:0] mem [0:(1 << ADDR_WIDTH) - 1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i]) begin
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;
endmodule

// File: rtl/data_mem_resp.sv
// RV32I data-memory responder: one load/store per handshake, response WAIT_CYCLES+1 cycles after acceptance.
// Backpressure: req_ready only in IDLE; response held stable until rsp_ready, no request overlap.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int ADDR_WIDTH  = 12,
    parameter int WAIT_CYCLES = 1
) (
    input logic            clk,
    input logic            rst,
    data_mem_resp_if.slave bus
);
    localparam logic [3:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    typedef struct packed {
        logic                  we;
        logic [2:0]            funct3;
        logic [ADDR_WIDTH-1:0] widx;
        logic [1:0]            off;
        logic [31:0]           wdata;
    } req_t;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    req_t        req_q, req_d, req_in, acc_req;
    logic        err_q, err_d, err_in, acc_err, acc_en;
    logic [3:0]  bram_we;
    logic [31:0] bram_wdata, bram_rdata, lane, ext;

    always_comb begin
        req_in.we     = bus.req_we;
        req_in.funct3 = bus.req_funct3;
        req_in.widx   = bus.req_addr[ADDR_WIDTH+1:2];
        req_in.off    = bus.req_addr[1:0];
        req_in.wdata  = bus.req_wdata;

        err_in = (bus.req_addr >> (ADDR_WIDTH + 2)) != 32'd0;
        if (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) err_in = 1'b1;
        if (bus.req_funct3 == F3_W && bus.req_addr[1:0] != 2'b00) err_in = 1'b1;
        if (bus.req_we) begin
            if (bus.req_funct3[2]) err_in = 1'b1;
        end else if (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                     bus.req_funct3 == 3'b111) begin
            err_in = 1'b1;
        end
    end

    // The array is touched exactly once per transaction, on the edge that enters RESP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        req_d   = req_q;
        err_d   = err_q;
        acc_en  = 1'b0;
        acc_req = req_q;
        acc_err = err_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    req_d = req_in;
                    err_d = err_in;
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                        acc_en  = 1'b1;
                        acc_req = req_in;
                        acc_err = err_in;
                    end else begin
                        state_d = WAIT;
                        cnt_d   = WAIT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    acc_en  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (bus.rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            req_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            err_q   <= err_d;
        end
    end

    assign bram_we    = (acc_en && acc_req.we && !acc_err) ?
                        byte_en(acc_req.funct3[1:0], acc_req.off) : 4'b0000;
    assign bram_wdata = store_lanes(acc_req.funct3[1:0], acc_req.wdata);

    dmem_bram #(.ADDR_WIDTH(ADDR_WIDTH)) u_bram (
        .clk   (clk),
        .en    (acc_en),
        .we    (bram_we),
        .addr  (acc_req.widx),
        .wdata (bram_wdata),
        .rdata (bram_rdata)
    );

    // Read data sits in the RAM's output register, so steering is applied on the way out.
    always_comb begin
        lane = bram_rdata >> {req_q.off, 3'b000};
        case (req_q.funct3)
            F3_B:    ext = {{24{lane[7]}}, lane[7:0]};
            F3_H:    ext = {{16{lane[15]}}, lane[15:0]};
            F3_W:    ext = lane;
            F3_BU:   ext = {24'd0, lane[7:0]};
            F3_HU:   ext = {16'd0, lane[15:0]};
            default: ext = 32'd0;
        endcase
    end

    assign bus.req_ready = (state_q == IDLE);
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_err   = (state_q == RESP) && err_q;
    assign bus.rsp_rdata = (state_q == RESP && !req_q.we && !err_q) ? ext : 32'd0;
endmodule

// File: tb/tb_data_mem_resp.sv
// Scoreboard bench for data_mem_resp: three instances (WAIT_CYCLES 1, 0, 3) exercised in turn
// against a byte-array reference model; a negedge monitor checks every response cycle.
module tb_data_mem_resp;
    import dmem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0, req_wdata = 32'd0;
    logic        rq_rdy, rs_vld, rs_err;
    logic [31:0] rs_dat;
    int          sel = 0;
    int          wc  = 1;
    int          wc_tab [3] = '{1, 0, 3};

    data_mem_resp_if bus0();
    data_mem_resp_if bus1();
    data_mem_resp_if bus2();

    assign bus0.req_valid = req_valid && (sel == 0);
    assign bus1.req_valid = req_valid && (sel == 1);
    assign bus2.req_valid = req_valid && (sel == 2);
    assign bus0.rsp_ready = rsp_ready && (sel == 0);
    assign bus1.rsp_ready = rsp_ready && (sel == 1);
    assign bus2.rsp_ready = rsp_ready && (sel == 2);
    assign bus0.req_we = req_we;  assign bus0.req_funct3 = req_funct3;
    assign bus0.req_addr = req_addr;  assign bus0.req_wdata = req_wdata;
    assign bus1.req_we = req_we;  assign bus1.req_funct3 = req_funct3;
    assign bus1.req_addr = req_addr;  assign bus1.req_wdata = req_wdata;
    assign bus2.req_we = req_we;  assign bus2.req_funct3 = req_funct3;
    assign bus2.req_addr = req_addr;  assign bus2.req_wdata = req_wdata;

    always_comb begin
        case (sel)
            0:       begin rq_rdy = bus0.req_ready; rs_vld = bus0.rsp_valid; rs_dat = bus0.rsp_rdata; rs_err = bus0.rsp_err; end
            1:       begin rq_rdy = bus1.req_ready; rs_vld = bus1.rsp_valid; rs_dat = bus1.rsp_rdata; rs_err = bus1.rsp_err; end
            default: begin rq_rdy = bus2.req_ready; rs_vld = bus2.rsp_valid; rs_dat = bus2.rsp_rdata; rs_err = bus2.rsp_err; end
        endcase
    end

    data_mem_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(1)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
    data_mem_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(0)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    data_mem_resp #(.ADDR_WIDTH(12), .WAIT_CYCLES(3)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    exp_t        sb [$];
    logic [7:0]  mem_m [3][16384];
    int          n_checks = 0, n_err = 0, cyc = 0, last_hs = -10, hold_left = 0;
    bit          rnd_rdy = 1'b0;
    logic        prev_vld = 1'b0;
    logic [2:0]  ld_ok [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    logic [2:0]  ld_bad [3] = '{3'd3, 3'd6, 3'd7};
    logic        t_w, t_err;
    logic [2:0]  t_f3;
    logic [31:0] t_a, t_rd;
    int          r;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (WAIT_CYCLES=%0d): got 0x%08h, expected 0x%08h", nm, wc, act, exp);
        end
    endfunction

    // Reference model: memory as a flat byte array, access size from funct3.
    function automatic void mdl(input int s, input logic w, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] d, input bit commit,
                                output logic [31:0] rd, output logic e);
        int unsigned size;
        logic [31:0] v;
        size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        e = (a % size) != 0;
        if (a >= 32'h4000) e = 1'b1;
        if (!w && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) e = 1'b1;
        if (w && f3 >= 3'd4) e = 1'b1;
        rd = 32'd0;
        if (!e) begin
            if (w) begin
                if (commit) for (int i = 0; i < int'(size); i++) mem_m[s][a + i] = d[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < int'(size); i++) v = v | (32'(mem_m[s][a + i]) << (8 * i));
                if (f3 < 3'd4 && size < 4 && v[8*size-1]) v = v | ~((32'd1 << (8 * size)) - 1);
                rd = v;
            end
        end
    endfunction

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        int   n;
        bit   busy;
        busy = (sb.size() != 0) || rs_vld;
        mdl(sel, w, f3, a, d, 1'b1, e.rdata, e.err);
        req_we = w; req_funct3 = f3; req_addr = a; req_wdata = d; req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!rq_rdy && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!rq_rdy) begin
            n_checks++; n_err++;
            $display("FAIL accept_timeout: req_ready stayed 0 for %0d cycles, required 1", n);
        end else begin
            e.acc = cyc;
            sb.push_back(e);
            if (busy) chk("accept_spacing", cyc, last_hs + 1);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || rs_vld) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 500) begin
            n_checks++; n_err++;
            $display("FAIL drain_timeout: %0d responses still pending, required 0", sb.size());
            sb.delete();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_req_ready"}, 32'(rq_rdy), 32'd1);
        chk({tag, "_rsp_valid"}, 32'(rs_vld), 32'd0);
        chk({tag, "_rsp_rdata"}, rs_dat, 32'd0);
        chk({tag, "_rsp_err"},   32'(rs_err), 32'd0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk); #1;
        if (hold_left > 0) begin
            rsp_ready = 1'b0;
            if (rs_vld) hold_left--;
        end else begin
            rsp_ready = rnd_rdy ? ($urandom_range(2) != 0) : 1'b1;
        end
    end

    // Monitor: compares every response cycle, so a held response must stay stable.
    initial forever begin
        @(negedge clk);
        if (rs_vld) begin
            if (sb.size() == 0) begin
                n_checks++; n_err++;
                $display("FAIL rsp_unexpected: rsp_valid=1 with rdata 0x%08h, required no response", rs_dat);
            end else begin
                chk("rsp_rdata", rs_dat, sb[0].rdata);
                chk("rsp_err", 32'(rs_err), 32'(sb[0].err));
                chk("req_ready_busy", 32'(rq_rdy), 32'd0);
                if (!prev_vld) chk("rsp_latency", 32'(cyc - sb[0].acc), 32'(wc + 1));
                if (rsp_ready) begin
                    void'(sb.pop_front());
                    last_hs = cyc;
                end
            end
        end
        prev_vld = rs_vld;
    end

    initial begin
        for (int s = 0; s < 3; s++) begin
            sel = s;
            wc = wc_tab[s];
            rnd_rdy = 1'b0;
            rst = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            chk_reset_outs("reset");
            @(posedge clk); #1;
            rst = 1'b1;

            for (int i = 0; i < 16; i++) issue(1'b1, F3_W, 32'(i * 4), $urandom);
            issue(1'b1, F3_W,  32'h10, 32'hDEADBEEF);
            issue(1'b0, F3_W,  32'h10, 32'h0);
            issue(1'b0, F3_B,  32'h13, 32'h0);
            issue(1'b0, F3_BU, 32'h13, 32'h0);
            issue(1'b0, F3_H,  32'h12, 32'h0);
            issue(1'b0, F3_HU, 32'h10, 32'h0);
            issue(1'b1, F3_B,  32'h11, 32'hA5A5A555);
            issue(1'b0, F3_W,  32'h10, 32'h0);
            issue(1'b0, F3_W,  32'h12, 32'h0);
            issue(1'b1, F3_W,  32'h4000, 32'hCAFEF00D);
            issue(1'b0, F3_W,  32'h0, 32'h0);
            issue(1'b1, F3_W,  32'h3FFC, 32'h0BADC0DE);
            issue(1'b0, F3_W,  32'h3FFC, 32'h0);
            issue(1'b0, F3_W,  32'h8000_0010, 32'h0);
            issue(1'b0, F3_HU, 32'h11, 32'h0);
            issue(1'b1, F3_H,  32'h16, 32'h1234ABCD);
            issue(1'b0, F3_W,  32'h14, 32'h0);
            drain();

            hold_left = 5;
            issue(1'b0, F3_W, 32'h10, 32'h0);
            issue(1'b1, F3_W, 32'h2C, 32'h600DF00D);
            drain();

            req_we = 1'b1; req_funct3 = F3_W; req_addr = 32'h20; req_wdata = 32'h12345678; req_valid = 1'b1;
            @(negedge clk);
            chk("midrst_accept", 32'(rq_rdy), 32'd1);
            @(posedge clk); #1;
            req_valid = 1'b0;
            rst = 1'b0;
            if (wc == 0) mdl(sel, 1'b1, F3_W, 32'h20, 32'h12345678, 1'b1, t_rd, t_err);
            @(negedge clk);
            chk_reset_outs("midrst");
            @(posedge clk); #1;
            rst = 1'b1;
            issue(1'b0, F3_W, 32'h20, 32'h0);
            drain();

            rnd_rdy = 1'b1;
            for (int i = 0; i < 150; i++) begin
                t_w = 1'($urandom_range(1));
                r = $urandom_range(9);
                if (!t_w) t_f3 = (r < 8) ? ld_ok[r % 5] : ld_bad[$urandom_range(2)];
                else      t_f3 = (r < 9) ? 3'(r % 3) : 3'(4 + $urandom_range(3));
                r = $urandom_range(15);
                if (r == 0)      t_a = 32'h4000 + $urandom_range(255);
                else if (r == 1) t_a = 32'h8000_0000 | $urandom_range(63);
                else             t_a = $urandom_range(63);
                issue(t_w, t_f3, t_a, $urandom);
            end
            drain();
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/data_mem_resp.md
# data_mem_resp

Data-memory responder for the 5-stage core: the target end of the MEM stage's load/store request interface. It accepts one RV32I load or store per handshake, inserts a configurable number of wait states, and performs byte/half/word accesses with byte-lane steering and load sign/zero extension. It returns read data and an error flag through a valid/ready response channel. It sits between MEM and the data-side memory array, replacing direct combinational data access.

## Interface
- `ADDR_WIDTH`, default 12: word-address bits; capacity is 2^ADDR_WIDTH 32-bit words.
- `WAIT_CYCLES`, default 1: wait states between acceptance and response; legal range 0–15.
- `clk` input, 1 bit: single clock; all logic is rising-edge.
- `rst` input, 1 bit: asynchronous, active-low reset.
- `req_valid` input, 1 bit: request present.
- `req_ready` output, 1 bit: responder can accept a request.
- `req_we` input, 1 bit: 1 means store, 0 means load.
- `req_funct3` input, 3 bits: RV32I funct3.
  - Loads: LB=000, LH=001, LW=010, LBU=100, LHU=101.
  - Stores: SB=000, SH=001, SW=010.
- `req_addr` input, 32 bits: byte address.
- `req_wdata` input, 32 bits: store data, right-aligned (bits [7:0] for SB, [15:0] for SH).
- `rsp_valid` output, 1 bit: response present.
- `rsp_ready` input, 1 bit: MEM consumes the response.
- `rsp_rdata` output, 32 bits: extended load data; 0 for stores and for errors.
- `rsp_err` output, 1 bit: the access was rejected (misaligned, out of range, or illegal funct3).

## Operation
- FSM states: IDLE, WAIT, RESP.
  - `req_ready` = 1 only in IDLE.
  - `rsp_valid` = 1 only in RESP.
- IDLE: when `req_valid` is high, latch `we`, `funct3`, `addr` and `wdata`, and evaluate the error condition.
  - If WAIT_CYCLES > 0, go to WAIT and load the counter with WAIT_CYCLES-1.
  - If WAIT_CYCLES = 0, go directly to RESP.
- WAIT: the counter decrements each cycle. At 0, perform the array access and go to RESP.
- RESP: hold `rsp_valid`, `rsp_rdata` and `rsp_err` stable until `rsp_ready` is high, then return to IDLE.
- Error conditions (`rsp_err`=1):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Any of addr[31:ADDR_WIDTH+2] nonzero.
  - funct3 in {011, 110, 111} for loads.
  - funct3[2]=1 for stores.
- An erroring store writes nothing. An erroring load returns 0.
- Store byte enables:
  - SB: 4'b0001 << addr[1:0].
  - SH: 4'b0011 << addr[1:0].
  - SW: 4'b1111.
  - Write data is replicated across lanes.
- Load: select the lane by addr[1:0]. LB/LH sign-extend; LBU/LHU zero-extend.

## Timing
- Reset values: FSM=IDLE, `req_ready`=1, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0. The array contents are not reset.
- Latency: `rsp_valid` rises WAIT_CYCLES+1 cycles after the acceptance edge.
- Minimum spacing between accepted requests is WAIT_CYCLES+2 cycles; there is no overlap.
- The array is a synchronous read/write port.
  - The store commits on the edge that enters RESP.
  - Load data is registered into `rsp_rdata` on that same edge.
- `req_valid` held high in WAIT or RESP is ignored, because `req_ready`=0.
- `rsp_ready` high outside RESP has no effect.
- Reset asserted mid-operation returns to IDLE immediately and drops `rsp_valid`.
  - A store not yet committed is discarded.
  - A committed store persists.
- A load to an address written in a previous transaction returns the new data (no stale read).

## Structure
- Package `dmem_pkg`: funct3 constants (`F3_B`, `F3_H`, `F3_W`, `F3_BU`, `F3_HU`), the state encoding (IDLE/WAIT/RESP), and the byte-enable function.
- Sub-module `dmem_bram`: single-port synchronous RAM with parameter ADDR_WIDTH and ports `clk`, `en`, `we[3:0]`, `addr`, `wdata`, `rdata`. It has no reset.
- Top level: FSM, wait counter, error check, lane steering and extension.

## Test plan
- Reset, then SW 0xDEADBEEF at addr 0x10, then LW at 0x10 with WAIT_CYCLES=1 → `rsp_valid` 2 cycles after acceptance, `rsp_rdata`=0xDEADBEEF, `rsp_err`=0.
- With 0xDEADBEEF at 0x10:
  - LB at 0x13 → 0xFFFFFFDE.
  - LBU at 0x13 → 0x000000DE.
  - LH at 0x12 → 0xFFFFDEAD.
  - LHU at 0x10 → 0x0000BEEF.
- SB 0x55 at 0x11 over 0xDEADBEEF, then LW at 0x10 → 0xDEAD55EF.
- Misaligned LW at 0x12 and out-of-range SW at 0x4000 (ADDR_WIDTH=12) → `rsp_err`=1, `rsp_rdata`=0; a following LW at 0x0 shows memory unchanged.
- Hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_valid`, `rsp_rdata` and `req_ready`=0 stay stable. A new `req_valid` in that window is not accepted until one cycle after the `rsp_ready` handshake.
- Assert `rst` low during WAIT of an SW 0x12345678 at 0x20 → outputs return to reset values; a later LW at 0x20 returns the old value. Repeat all scenarios with WAIT_CYCLES=0 → response 1 cycle after acceptance.
